// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: producer request/ack bundle plus the UART transmit handshake.
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DATA_W = 8
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] req_ack;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [DATA_W-1:0] tx_data;
  logic tx_stb;
  logic tx_busy;
  modport master (input req, req_data, tx_busy, output req_ack, tx_data, tx_stb);
  modport slave (output req, req_data, tx_busy, input req_ack, tx_data, tx_stb);
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmit port among NREQ frame producers.
module uart_tx_arbiter #(
  parameter int NREQ = 4,
  parameter int DATA_W = 8,
  parameter int BUSY_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  uart_tx_arbiter_if.master bus,
  output logic [2:0] grant_id,
  output logic active,
  output logic timeout_err,
  output logic [15:0] frames_sent
);
  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;
  state_t state, state_n;
  logic [2:0] last, win;
  logic [3:0] cnt;
  logic grant, done, tmo;
  // scan offsets high-to-low so the smallest offset from last+1 overrides
  always_comb begin
    win = last;
    for (int k = NREQ; k >= 1; k--)
      if (|((bus.req >> ((int'(last) + k) % NREQ)) & NREQ'(1))) win = 3'((int'(last) + k) % NREQ);
  end
  always_comb begin
    state_n = state;
    grant = 1'b0;
    done = 1'b0;
    tmo = 1'b0;
    case (state)
      IDLE: begin
        grant = en && |bus.req;
        state_n = grant ? WAIT_BUSY : IDLE;
      end
      WAIT_BUSY: begin
        tmo = !bus.tx_busy && cnt == 4'(BUSY_WAIT);
        state_n = bus.tx_busy ? WAIT_DONE : tmo ? IDLE : WAIT_BUSY;
      end
      WAIT_DONE: begin
        done = !bus.tx_busy;
        state_n = done ? IDLE : WAIT_DONE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last <= 3'(NREQ - 1);
      cnt <= '0;
      grant_id <= '0;
      active <= 1'b0;
      timeout_err <= 1'b0;
      frames_sent <= '0;
      bus.tx_stb <= 1'b0;
      bus.req_ack <= '0;
      bus.tx_data <= '0;
    end else begin
      cnt <= state == WAIT_BUSY ? cnt + 4'd1 : '0;
      active <= state_n != IDLE;
      bus.tx_stb <= grant;
      bus.req_ack <= grant ? NREQ'(1) << win : '0;
      if (grant) begin
        bus.tx_data <= DATA_W'(bus.req_data >> (int'(win) * DATA_W));
        grant_id <= win;
        last <= win;
      end
      if (tmo) timeout_err <= 1'b1;
      if (done) frames_sent <= frames_sent + 16'd1;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized checks of uart_tx_arbiter against an edge-indexed transaction model.
module tb_uart_tx_arbiter;
  localparam int NREQ = 4, DATA_W = 8, BUSY_WAIT = 4;
  logic clk = 1'b0, rst = 1'b0, en = 1'b0;
  logic [2:0] grant_id;
  logic active, timeout_err;
  logic [15:0] frames_sent;
  uart_tx_arbiter_if #(.NREQ(NREQ), .DATA_W(DATA_W)) bus();
  uart_tx_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .BUSY_WAIT(BUSY_WAIT)) dut (
    .clk(clk), .rst(rst), .en(en), .bus(bus), .grant_id(grant_id), .active(active),
    .timeout_err(timeout_err), .frames_sent(frames_sent));
  always #5 clk = ~clk;
  int total = 0, bad = 0, cyc = 0;
  bit in_frame, seen_rise, stb_exp, tmo_exp;
  int g_edge, last_w;
  logic [NREQ-1:0] ack_exp;
  logic [DATA_W-1:0] data_exp;
  logic [2:0] gid_exp;
  logic [15:0] sent_exp;
  int lat = 1, dur = 3, re_delay = -1, u_wait = 0, u_left = 0;
  int rearm [NREQ];
  bit rand_mode = 0;
  int n_stb, n_ack, stb_cyc, tmo_cyc;
  int order [$];
  int rr_exp [6] = '{0, 1, 2, 3, 0, 1};
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic int pick(logic [NREQ-1:0] r);
    for (int k = 1; k <= NREQ; k++) if (r[(last_w + k) % NREQ]) return (last_w + k) % NREQ;
    return -1;
  endfunction
  function automatic void model_reset();
    in_frame = 0; seen_rise = 0; stb_exp = 0; tmo_exp = 0;
    ack_exp = '0; data_exp = '0; gid_exp = '0; sent_exp = '0; last_w = NREQ - 1;
  endfunction
  // one call per rising edge, using the inputs the DUT sampled at that edge
  function automatic void model_edge();
    int w;
    stb_exp = 0;
    ack_exp = '0;
    if (!in_frame) begin
      w = pick(bus.req);
      if (en && w >= 0) begin
        stb_exp = 1; ack_exp = NREQ'(1 << w); gid_exp = 3'(w); last_w = w;
        data_exp = bus.req_data[w*DATA_W +: DATA_W];
        in_frame = 1; seen_rise = 0; g_edge = cyc;
      end
    end else if (!seen_rise) begin
      if (bus.tx_busy) seen_rise = 1;
      else if (cyc - g_edge > BUSY_WAIT) begin tmo_exp = 1; in_frame = 0; end
    end else if (!bus.tx_busy) begin
      sent_exp = sent_exp + 16'd1;
      in_frame = 0;
    end
  endfunction
  task automatic step();
    @(negedge clk);
    cyc++;
    if (!rst) model_reset(); else model_edge();
    check("stb", 32'(bus.tx_stb), 32'(stb_exp));
    check("ack", 32'(bus.req_ack), 32'(ack_exp));
    check("tx_data", 32'(bus.tx_data), 32'(data_exp));
    check("grant_id", 32'(grant_id), 32'(gid_exp));
    check("active", 32'(active), 32'(in_frame));
    check("timeout_err", 32'(timeout_err), 32'(tmo_exp));
    check("frames_sent", 32'(frames_sent), 32'(sent_exp));
    check("stb_while_busy", 32'(bus.tx_stb & bus.tx_busy), 32'(0));
    if (bus.tx_stb) begin n_stb++; stb_cyc = cyc; order.push_back(int'(grant_id)); end
    n_ack += $countones(bus.req_ack);
    if (timeout_err && tmo_cyc < 0) tmo_cyc = cyc;
    if (u_left > 0) begin
      u_left--;
      if (u_left == 0) bus.tx_busy = 1'b0;
    end else if (u_wait > 0) begin
      u_wait--;
      if (u_wait == 0) begin bus.tx_busy = 1'b1; u_left = dur; end
    end
    if (bus.tx_stb) begin
      if (rand_mode) begin
        lat = $urandom_range(0, 9) == 0 ? -1 : int'($urandom_range(0, 2));
        dur = int'($urandom_range(1, 5));
      end
      if (lat == 0) begin bus.tx_busy = 1'b1; u_left = dur; end
      else if (lat > 0) u_wait = lat;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (bus.req_ack[i]) begin
        bus.req[i] = 1'b0;
        rearm[i] = rand_mode ? int'($urandom_range(1, 6)) : re_delay;
      end else if (rearm[i] > 0) begin
        rearm[i]--;
        if (rearm[i] == 0) begin
          bus.req[i] = 1'b1;
          bus.req_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
        end
      end
    end
    if (rand_mode && $urandom_range(0, 7) == 0) en = ~en;
  endtask
  task automatic restart();
    rst = 1'b0;
    bus.req = '0; bus.tx_busy = 1'b0; u_wait = 0; u_left = 0; rand_mode = 0;
    for (int i = 0; i < NREQ; i++) rearm[i] = 0;
    repeat (2) step();
    rst = 1'b1;
    n_stb = 0; n_ack = 0; tmo_cyc = -1; stb_cyc = -1;
    order.delete();
  endtask
  initial begin
    bus.req = '0; bus.req_data = '0; bus.tx_busy = 1'b0;
    model_reset();
    restart();
    en = 1'b1; lat = 1; dur = 20; re_delay = -1;
    bus.req_data[7:0] = 8'h41; bus.req = 4'b0001;
    repeat (40) step();
    check("single_stb_count", 32'(n_stb), 32'(1));
    check("single_ack_count", 32'(n_ack), 32'(1));
    check("single_frames", 32'(frames_sent), 32'(1));
    check("single_grant", 32'(grant_id), 32'(0));
    check("single_data", 32'(bus.tx_data), 32'h41);
    restart();
    lat = 1; dur = 3; re_delay = 2;
    bus.req_data = NREQ*DATA_W'($urandom);
    bus.req = 4'b1111;
    for (int i = 0; i < 200 && order.size() < 6; i++) step();
    check("rr_count", 32'(order.size() >= 6), 32'(1));
    for (int i = 0; i < 6; i++) check("rr_order", 32'(i < order.size() ? order[i] : -1), 32'(rr_exp[i]));
    restart();
    lat = 0; dur = 1; re_delay = -1;
    bus.req = 4'b1010;
    for (int i = 0; i < 50 && order.size() < 2; i++) step();
    check("simul_first", 32'(order.size() > 0 ? order[0] : -1), 32'(1));
    check("simul_second", 32'(order.size() > 1 ? order[1] : -1), 32'(3));
    restart();
    lat = -1;
    bus.req = 4'b0001;
    for (int i = 0; i < 50 && tmo_cyc < 0; i++) step();
    check("timeout_delay", 32'(tmo_cyc - stb_cyc), 32'(5));
    repeat (2) step();
    check("timeout_frames", 32'(frames_sent), 32'(0));
    check("timeout_idle", 32'(active), 32'(0));
    n_stb = 0; lat = 1; dur = 8;
    bus.req_data[7:0] = 8'h3C; bus.req[0] = 1'b1;
    for (int i = 0; i < 20 && !bus.tx_busy; i++) step();
    step();
    en = 1'b0;
    bus.req_data[23:16] = 8'h5A; bus.req[2] = 1'b1;
    repeat (20) step();
    check("en_frames", 32'(frames_sent), 32'(1));
    check("en_stb_count", 32'(n_stb), 32'(1));
    check("en_idle", 32'(active), 32'(0));
    check("en_sticky", 32'(timeout_err), 32'(1));
    en = 1'b1;
    for (int i = 0; i < 10 && n_stb < 2; i++) step();
    check("en_grant", 32'(grant_id), 32'(2));
    check("en_data", 32'(bus.tx_data), 32'h5A);
    rst = 1'b0;
    #1;
    check("rst_stb", 32'(bus.tx_stb), 32'(0));
    check("rst_ack", 32'(bus.req_ack), 32'(0));
    check("rst_data", 32'(bus.tx_data), 32'(0));
    check("rst_grant", 32'(grant_id), 32'(0));
    check("rst_active", 32'(active), 32'(0));
    check("rst_timeout", 32'(timeout_err), 32'(0));
    check("rst_frames", 32'(frames_sent), 32'(0));
    bus.req = '0;
    repeat (12) step();
    rst = 1'b1;
    repeat (4) step();
    check("rst_uncounted", 32'(frames_sent), 32'(0));
    force dut.frames_sent = 16'hFFFF;
    #1;
    release dut.frames_sent;
    sent_exp = 16'hFFFF;
    lat = 0; dur = 2;
    bus.req_data[7:0] = 8'h77; bus.req[0] = 1'b1;
    repeat (15) step();
    check("wrap", 32'(frames_sent), 32'(0));
    restart();
    rand_mode = 1; en = 1'b1;
    bus.req_data = NREQ*DATA_W'($urandom);
    bus.req = '1;
    repeat (3000) step();
    check("rand_progress", 32'(n_stb > 20), 32'(1));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
